// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level helpers.
// Used by the CBC/ECB controller (AES_CBC_EN) and the iterative core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_t;

  localparam int AES_BLK_W = 128;

  localparam int AES128_N  = 128;
  localparam int AES128_NR = 10;
  localparam int AES128_NK = 4;
  localparam int AES192_N  = 192;
  localparam int AES192_NR = 12;
  localparam int AES192_NK = 6;
  localparam int AES256_N  = 256;
  localparam int AES256_NR = 14;
  localparam int AES256_NK = 8;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(
    input int i
  );
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < i; j++) r = xtime(r);
    return r;
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns.
  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic         last
  );
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        b[4*c+k] = a[4*((c+k)%4)+k];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      c0 = b[4*c];
      c1 = b[4*c+1];
      c2 = b[4*c+2];
      c3 = b[4*c+3];
      if (last)
        r[127-32*c -: 32] = {c0, c1, c2, c3};
      else
        r[127-32*c -: 32] = {
          xtime(c0) ^ xtime(c1) ^ c1 ^ c2 ^ c3,
          c0 ^ xtime(c1) ^ xtime(c2) ^ c2 ^ c3,
          c0 ^ c1 ^ xtime(c2) ^ xtime(c3) ^ c3,
          xtime(c0) ^ c0 ^ c1 ^ c2 ^ xtime(c3)
        };
    end
    return r;
  endfunction

endpackage

// File: rtl/Encrypt_Iterative.sv
// Iterative AES encrypt core: one round per clock.
// done pulses one cycle with out holding the ciphertext.
module Encrypt_Iterative
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] in,
  input  logic [N-1:0]         key,
  output logic [AES_BLK_W-1:0] out,
  output logic                 done
);

  localparam int NW = 4 * (Nr + 1);
  localparam int KW = 32 * NW;

  logic [KW-1:0]  sched;
  logic [127:0]   st;
  logic [127:0]   rk0;
  logic [127:0]   rk;
  logic [3:0]     rnd;
  logic           active;

  function automatic logic [KW-1:0] expand(
    input logic [N-1:0] k
  );
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = k[N-1-32*(i%Nk) -: 32];
      end else begin
        t = w[i-1];
        if (i % Nk == 0)
          t = sub_word({t[23:0], t[31:24]})
              ^ {rcon(i / Nk), 24'h0};
        else if (Nk > 6 && i % Nk == 4)
          t = sub_word(t);
        w[i] = w[i-Nk] ^ t;
      end
      r[32*(NW-1-i) +: 32] = w[i];
    end
    return r;
  endfunction

  // Whole key schedule from the (held) key.
  always_comb sched = expand(key);

  // Whitening key and key of the round being applied.
  always_comb begin
    rk0 = sched[KW-1 -: 128];
    rk  = sched[32*(NW-4-4*int'(rnd)) +: 128];
  end

  // Load on start, then one round per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= '0;
      rnd    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        st     <= in ^ rk0;
        rnd    <= 4'd1;
        active <= 1'b1;
      end else if (active) begin
        st <= aes_round(st, rnd == 4'(Nr)) ^ rk;
        if (rnd == 4'(Nr)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

  assign out = st;

endmodule

// File: rtl/aes_cbc_encrypt_ctrl.sv
// Stream front end for the iterative AES core.
// AES_CBC_EN defined: CBC chaining; undefined: ECB.
module aes_cbc_encrypt_ctrl
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         key,
  input  logic                 key_load,
  input  logic [AES_BLK_W-1:0] iv,
  input  logic                 iv_load,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [AES_BLK_W-1:0] pt_data,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [AES_BLK_W-1:0] ct_data,
  output logic                 busy,
  output logic [31:0]          blk_cnt
);

  state_t               state;
  logic [N-1:0]         key_reg;
  logic                 key_valid;
  logic [AES_BLK_W-1:0] blk_reg;
  logic                 core_start;
  logic                 core_done;
  logic [AES_BLK_W-1:0] core_out;
  logic                 load_any;

`ifdef AES_CBC_EN
  logic [AES_BLK_W-1:0] chain;
  assign load_any = key_load | iv_load;
`else
  logic unused_iv;
  assign unused_iv = ^{iv, iv_load};
  assign load_any  = key_load;
`endif

  // Loads take priority over accepting a block.
  assign pt_ready = (state == IDLE) & key_valid & !load_any;
  assign busy     = (state != IDLE);

  // Drop start in the done cycle so the core stays idle.
  assign core_start = (state == RUN) & !core_done;

  // Block FSM: IDLE -> RUN -> OUT -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      key_valid <= 1'b0;
      blk_reg   <= '0;
      ct_valid  <= 1'b0;
      ct_data   <= '0;
      blk_cnt   <= '0;
`ifdef AES_CBC_EN
      chain     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (key_load) begin
            key_reg   <= key;
            key_valid <= 1'b1;
          end
`ifdef AES_CBC_EN
          if (iv_load) chain <= iv;
`endif
          if (pt_valid && pt_ready) begin
`ifdef AES_CBC_EN
            blk_reg <= pt_data ^ chain;
`else
            blk_reg <= pt_data;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            ct_data  <= core_out;
            ct_valid <= 1'b1;
`ifdef AES_CBC_EN
            chain    <= core_out;
`endif
            state    <= OUT;
          end
        end
        OUT: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            blk_cnt  <= blk_cnt + 32'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  Encrypt_Iterative #(
    .N  (N),
    .Nr (Nr),
    .Nk (Nk)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start),
    .in    (blk_reg),
    .key   (key_reg),
    .out   (core_out),
    .done  (core_done)
  );

endmodule
